// File: rtl/pulse_arb_pkg.sv
// Shared types and constants for the pulse arbiter.
// The optional drop counter is enabled with the PULSE_ARB_DROP_CNT_EN macro.
package pulse_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GRANT     = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_e;

  localparam int DROP_CNT_W = 8;

  // Number of set bits in a vector of up to 16 channels.
  function automatic logic [4:0] count_ones(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) begin
      n = n + {4'b0000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/pulse_arb_rr_pick.sv
// Round-robin search: first pending channel after last_id, wrapping modulo N_REQ.
module rr_pick
  import pulse_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] pend_vec,
  input  logic [ID_W-1:0]  last_id,
  output logic             found,
  output logic [ID_W-1:0]  next_id
);

  // Channel index reached by stepping off positions past base.
  function automatic int wrap_idx(input int base, input int off);
    int s;
    s = base + off;
    if (s >= N_REQ) s = s - N_REQ;
    return s;
  endfunction

  logic [ID_W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest pending channel wins.
  always_comb begin
    found   = 1'b0;
    next_id = '0;
    cand    = '0;
    for (int off = N_REQ; off >= 1; off--) begin
      cand = ID_W'(wrap_idx(int'(last_id), off));
      if (pend_vec[cand]) begin
        found   = 1'b1;
        next_id = cand;
      end
    end
  end

endmodule

// File: rtl/pulse_arb.sv
// Pulse arbiter: turns rising edges of level requests into pending events and
// grants a shared resource round-robin, one job at a time.
// Grant handshake: grant_vld pulses for exactly one cycle when a job is issued;
// busy stays high until res_done is sampled high in WAIT_DONE, which releases
// the resource. res_done is ignored at every other time.
// Optional feature: define PULSE_ARB_DROP_CNT_EN to add the drop_cnt output.
module pulse_arb
  import pulse_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_lvl,
  input  logic             res_done,
  input  logic             clr_err,
  output logic             grant_vld,
  output logic [ID_W-1:0]  grant_id,
  output logic             busy,
  output logic [N_REQ-1:0] pend_vec,
  output logic [N_REQ-1:0] ovf_err,
  output arb_state_e       state_dbg
`ifdef PULSE_ARB_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] lvl_q, pend_q, ovf_q;
  logic [N_REQ-1:0] rise, grant_clr, drop_vec, pend_d, ovf_d;
  logic [ID_W-1:0]  last_id_q, grant_id_q, pick_id;
  logic             pick_found, grant_take;

  assign rise = req_lvl & ~lvl_q;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .pend_vec (pend_q),
    .last_id  (last_id_q),
    .found    (pick_found),
    .next_id  (pick_id)
  );

  // State register; reset abandons any outstanding grant.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state and state-decoded outputs.
  always_comb begin
    state_d    = state_q;
    grant_take = 1'b0;
    grant_vld  = 1'b0;
    busy       = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d    = GRANT;
          grant_take = 1'b1;
        end
      end
      GRANT: begin
        grant_vld = 1'b1;
        busy      = 1'b1;
        state_d   = WAIT_DONE;
      end
      WAIT_DONE: begin
        busy = 1'b1;
        if (res_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pending/overflow update: a grant clears its bit, a rise re-sets it, and a
  // rise onto a bit that stays pending is dropped and flagged.
  always_comb begin
    grant_clr = grant_take ? (N_REQ'(1) << pick_id) : '0;
    drop_vec  = rise & pend_q & ~grant_clr;
    pend_d    = (pend_q & ~grant_clr) | rise;
    ovf_d     = (clr_err ? '0 : ovf_q) | drop_vec;
  end

  // Edge-detect history, pending events and sticky overflow flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lvl_q  <= '0;
      pend_q <= '0;
      ovf_q  <= '0;
    end else begin
      lvl_q  <= req_lvl;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
    end
  end

  // Granted channel and round-robin pointer, both captured on grant entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      grant_id_q <= '0;
      last_id_q  <= ID_W'(N_REQ - 1);
    end else if (grant_take) begin
      grant_id_q <= pick_id;
      last_id_q  <= pick_id;
    end
  end

  assign grant_id  = grant_id_q;
  assign pend_vec  = pend_q;
  assign ovf_err   = ovf_q;
  assign state_dbg = state_q;

`ifdef PULSE_ARB_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q, cnt_base, drop_cnt_d;
  logic [DROP_CNT_W:0]   drop_sum;
  logic [4:0]            drop_pop;

  // Saturating sum of drops; a clear restarts from zero but same-edge drops still count.
  always_comb begin
    drop_pop   = count_ones(16'(drop_vec));
    cnt_base   = clr_err ? '0 : drop_cnt_q;
    drop_sum   = {1'b0, cnt_base} + (DROP_CNT_W + 1)'(drop_pop);
    drop_cnt_d = drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
  end

  // Drop counter register.
  always_ff @(posedge clk) begin
    if (!rst) drop_cnt_q <= '0;
    else      drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_pulse_arb.sv
// Self-checking bench for pulse_arb: directed scenarios plus randomized traffic
// compared each cycle against an event-level reference model.
module tb_pulse_arb;
  import pulse_arb_pkg::*;

  localparam int N = 4;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req_lvl;
  logic         res_done;
  logic         clr_err;
  logic         grant_vld;
  logic [1:0]   grant_id;
  logic         busy;
  logic [N-1:0] pend_vec;
  logic [N-1:0] ovf_err;
  arb_state_e   state_dbg;
`ifdef PULSE_ARB_DROP_CNT_EN
  logic [7:0]   drop_cnt;
`endif

  always #5 clk = ~clk;

  pulse_arb #(.N_REQ(N), .ID_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_lvl   (req_lvl),
    .res_done  (res_done),
    .clr_err   (clr_err),
    .grant_vld (grant_vld),
    .grant_id  (grant_id),
    .busy      (busy),
    .pend_vec  (pend_vec),
    .ovf_err   (ovf_err),
    .state_dbg (state_dbg)
`ifdef PULSE_ARB_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  // Events: a request going from low to high. Each channel holds at most one
  // waiting event; a grant is issued from an idle resource to the next waiting
  // channel after the last one served, occupies one cycle, then waits for done.
  logic [N-1:0] m_lvl, m_pend, m_ovf, m_evt;
  arb_state_e   m_state;
  int           m_last, m_id, m_drop, m_pick, m_drops, m_c;
  logic [1:0]   exp_q[$];

  always @(posedge clk) begin
    if (!rst) begin
      m_lvl   = '0;
      m_pend  = '0;
      m_ovf   = '0;
      m_state = IDLE;
      m_last  = N - 1;
      m_id    = 0;
      m_drop  = 0;
    end else begin
      m_pick = -1;
      if (m_state == IDLE) begin
        for (int off = 1; off <= N; off++) begin
          m_c = (m_last + off) % N;
          if (m_pick < 0 && m_pend[m_c]) m_pick = m_c;
        end
      end
      m_evt = req_lvl & ~m_lvl;
      m_lvl = req_lvl;
      if (clr_err) begin
        m_ovf  = '0;
        m_drop = 0;
      end
      m_drops = 0;
      for (int i = 0; i < N; i++) begin
        if (i == m_pick) m_pend[i] = m_evt[i];
        else if (m_evt[i]) begin
          if (m_pend[i]) begin
            m_ovf[i] = 1'b1;
            m_drops++;
          end else begin
            m_pend[i] = 1'b1;
          end
        end
      end
      m_drop = (m_drop + m_drops > 255) ? 255 : m_drop + m_drops;
      case (m_state)
        IDLE: if (m_pick >= 0) begin
          m_state = GRANT;
          m_id    = m_pick;
          m_last  = m_pick;
          exp_q.push_back(2'(m_pick));
        end
        GRANT:     m_state = WAIT_DONE;
        default:   if (res_done) m_state = IDLE;
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0; req_lvl = '0; res_done = 1'b0; clr_err = 1'b0;
    tick(); tick();
    rst = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0; req_lvl = 4'b1111; res_done = 1'b1; clr_err = 1'b0;
    tick(); tick();
    checks++; if (grant_vld !== 1'b0) begin failures++; $display("FAIL reset_grant_vld: got %b expected 0", grant_vld); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL reset_grant_id: got %0d expected 0", grant_id); end
    checks++; if (pend_vec !== 4'b0000) begin failures++; $display("FAIL reset_pend: got %b expected 0000", pend_vec); end
    checks++; if (ovf_err !== 4'b0000) begin failures++; $display("FAIL reset_ovf: got %b expected 0000", ovf_err); end
    checks++; if (state_dbg !== IDLE) begin failures++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, IDLE); end
    req_lvl = '0; res_done = 1'b0;
  endtask

  task automatic test_single_grant();
    do_reset();
    tick(); tick();                 // edges 1 and 2
    req_lvl = 4'b0100;
    tick();                         // edge 3: rise on ch2
    checks++; if (pend_vec !== 4'b0100) begin failures++; $display("FAIL single_pend: got %b expected 0100", pend_vec); end
    checks++; if (grant_vld !== 1'b0) begin failures++; $display("FAIL single_early_grant: got %b expected 0", grant_vld); end
    res_done = 1'b1;                // must be ignored in IDLE and GRANT
    tick();                         // edge 4: grant
    checks++; if (grant_vld !== 1'b1 || grant_id !== 2'd2) begin failures++; $display("FAIL single_grant: got vld=%b id=%0d expected vld=1 id=2", grant_vld, grant_id); end
    checks++; if (pend_vec !== 4'b0000) begin failures++; $display("FAIL single_pend_clr: got %b expected 0000", pend_vec); end
    tick();
    checks++; if (state_dbg !== WAIT_DONE || busy !== 1'b1 || grant_vld !== 1'b0) begin failures++; $display("FAIL single_wait: got state=%0d busy=%b vld=%b expected state=%0d busy=1 vld=0", state_dbg, busy, grant_vld, WAIT_DONE); end
    tick();
    checks++; if (state_dbg !== IDLE || busy !== 1'b0) begin failures++; $display("FAIL single_done: got state=%0d busy=%b expected state=%0d busy=0", state_dbg, busy, IDLE); end
    res_done = 1'b0; req_lvl = '0;
    tick();
  endtask

  task automatic test_round_robin();
    logic [1:0] ids [3];
    ids[0] = 2'd0; ids[1] = 2'd1; ids[2] = 2'd3;
    do_reset();
    req_lvl = 4'b1011;
    tick();
    checks++; if (pend_vec !== 4'b1011) begin failures++; $display("FAIL rr_pend: got %b expected 1011", pend_vec); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (grant_vld !== 1'b1 || grant_id !== ids[k]) begin failures++; $display("FAIL rr_grant%0d: got vld=%b id=%0d expected vld=1 id=%0d", k, grant_vld, grant_id, ids[k]); end
      tick(); tick();
      res_done = 1'b1;
      tick();
      res_done = 1'b0;
      checks++; if (busy !== 1'b0 || grant_vld !== 1'b0) begin failures++; $display("FAIL rr_idle_gap%0d: got busy=%b vld=%b expected 0 0", k, busy, grant_vld); end
    end
    checks++; if (pend_vec !== 4'b0000) begin failures++; $display("FAIL rr_pend_end: got %b expected 0000", pend_vec); end
    req_lvl = '0;
  endtask

  task automatic test_overflow();
    int n_grant;
    do_reset();
    req_lvl = 4'b0001; tick(); tick(); tick();  // ch0 granted, now waiting
    req_lvl = 4'b0011; tick();
    req_lvl = 4'b0001; tick();
    req_lvl = 4'b0011; tick();                  // second ch1 rise while pending
    checks++; if (ovf_err !== 4'b0010) begin failures++; $display("FAIL ovf_set: got %b expected 0010", ovf_err); end
    checks++; if (pend_vec !== 4'b0010) begin failures++; $display("FAIL ovf_pend: got %b expected 0010", pend_vec); end
    res_done = 1'b1; tick();
    res_done = 1'b0; tick();
    checks++; if (grant_vld !== 1'b1 || grant_id !== 2'd1) begin failures++; $display("FAIL ovf_grant: got vld=%b id=%0d expected vld=1 id=1", grant_vld, grant_id); end
    tick();
    res_done = 1'b1; tick();
    res_done = 1'b0;
    n_grant = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (grant_vld === 1'b1) n_grant++;
    end
    checks++; if (n_grant != 0) begin failures++; $display("FAIL ovf_single_grant: got %0d extra grants expected 0", n_grant); end
    checks++; if (ovf_err !== 4'b0010) begin failures++; $display("FAIL ovf_sticky: got %b expected 0010", ovf_err); end
    clr_err = 1'b1; tick();
    clr_err = 1'b0;
    checks++; if (ovf_err !== 4'b0000) begin failures++; $display("FAIL ovf_clear: got %b expected 0000", ovf_err); end
    // clear coinciding with a new overflow: the overflow wins
    req_lvl = 4'b0000; tick();
    req_lvl = 4'b0001; tick(); tick(); tick();
    req_lvl = 4'b0011; tick();
    req_lvl = 4'b0001; tick();
    req_lvl = 4'b0011; clr_err = 1'b1; tick();
    clr_err = 1'b0;
    checks++; if (ovf_err !== 4'b0010) begin failures++; $display("FAIL ovf_clr_collide: got %b expected 0010", ovf_err); end
  endtask

  task automatic test_reset_in_wait();
    int n_grant;
    do_reset();
    req_lvl = 4'b0001; tick(); tick(); tick();  // ch0 granted, waiting
    req_lvl = 4'b1001; tick();                  // ch3 pending
    checks++; if (pend_vec !== 4'b1000 || state_dbg !== WAIT_DONE) begin failures++; $display("FAIL rw_setup: got pend=%b state=%0d expected pend=1000 state=%0d", pend_vec, state_dbg, WAIT_DONE); end
    rst = 1'b0; tick();
    checks++; if (grant_vld !== 1'b0 || busy !== 1'b0 || grant_id !== 2'd0 || pend_vec !== 4'b0000 || ovf_err !== 4'b0000) begin failures++; $display("FAIL rw_outputs: got vld=%b busy=%b id=%0d pend=%b ovf=%b expected all 0", grant_vld, busy, grant_id, pend_vec, ovf_err); end
    checks++; if (state_dbg !== IDLE) begin failures++; $display("FAIL rw_state: got %0d expected %0d", state_dbg, IDLE); end
    req_lvl = 4'b0001; rst = 1'b1; tick();      // held-high ch0 makes one event
    checks++; if (pend_vec !== 4'b0001) begin failures++; $display("FAIL rw_held_evt: got %b expected 0001", pend_vec); end
    tick();
    checks++; if (grant_vld !== 1'b1 || grant_id !== 2'd0) begin failures++; $display("FAIL rw_grant: got vld=%b id=%0d expected vld=1 id=0", grant_vld, grant_id); end
    tick();
    res_done = 1'b1; tick();
    res_done = 1'b0;
    n_grant = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (grant_vld === 1'b1) n_grant++;
    end
    checks++; if (n_grant != 0) begin failures++; $display("FAIL rw_no_regrant: got %0d extra grants expected 0", n_grant); end
    req_lvl = '0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    req_lvl = 4'b0001; tick();
    req_lvl = 4'b0000; tick(); tick();          // ch0 granted, waiting
    req_lvl = 4'b0010; tick();
    req_lvl = 4'b0000; res_done = 1'b1; tick(); // back in IDLE, ch1 pending
    res_done = 1'b0; req_lvl = 4'b0010; tick(); // rise on ch1's grant-latch edge
    checks++; if (grant_vld !== 1'b1 || grant_id !== 2'd1) begin failures++; $display("FAIL b2b_grant1: got vld=%b id=%0d expected vld=1 id=1", grant_vld, grant_id); end
    checks++; if (pend_vec[1] !== 1'b1 || ovf_err !== 4'b0000) begin failures++; $display("FAIL b2b_pend_keep: got pend=%b ovf=%b expected pend[1]=1 ovf=0000", pend_vec, ovf_err); end
    req_lvl = 4'b0000; tick();
    res_done = 1'b1; tick();
    res_done = 1'b0; tick();
    checks++; if (grant_vld !== 1'b1 || grant_id !== 2'd1) begin failures++; $display("FAIL b2b_grant2: got vld=%b id=%0d expected vld=1 id=1", grant_vld, grant_id); end
    tick();
    res_done = 1'b1; tick();
    res_done = 1'b0;
  endtask

`ifdef PULSE_ARB_DROP_CNT_EN
  task automatic test_drop_cnt();
    do_reset();
    req_lvl = 4'b0001; tick(); tick(); tick();  // ch0 granted, waiting forever
    req_lvl = 4'b1111; tick();                  // ch1..3 pending
    for (int i = 0; i < 100; i++) begin
      req_lvl = 4'b0001; tick();
      req_lvl = 4'b1111; tick();                // three drops per edge
    end
    checks++; if (drop_cnt !== 8'd255) begin failures++; $display("FAIL drop_sat: got %0d expected 255", drop_cnt); end
    req_lvl = 4'b0001; tick();
    req_lvl = 4'b0011; clr_err = 1'b1; tick();
    checks++; if (drop_cnt !== 8'd1) begin failures++; $display("FAIL drop_clr_collide: got %0d expected 1", drop_cnt); end
    tick();
    clr_err = 1'b0;
    checks++; if (drop_cnt !== 8'd0) begin failures++; $display("FAIL drop_clr: got %0d expected 0", drop_cnt); end
    req_lvl = '0;
  endtask
`endif

  task automatic test_random();
    logic [1:0] exp_id;
    do_reset();
    tick();
    exp_q.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      if ($urandom_range(0, 1) == 0) req_lvl = 4'($urandom_range(0, 15));
      res_done = ($urandom_range(0, 2) == 0);
      clr_err  = ($urandom_range(0, 11) == 0);
      rst      = ($urandom_range(0, 149) != 0);
      tick();
      checks++; if (grant_vld !== (m_state == GRANT) || busy !== (m_state != IDLE)) begin failures++; $display("FAIL rnd_ctl cyc%0d: got vld=%b busy=%b expected state %0d", cyc, grant_vld, busy, m_state); end
      checks++; if (state_dbg !== m_state) begin failures++; $display("FAIL rnd_state cyc%0d: got %0d expected %0d", cyc, state_dbg, m_state); end
      checks++; if (grant_id !== 2'(m_id)) begin failures++; $display("FAIL rnd_id cyc%0d: got %0d expected %0d", cyc, grant_id, m_id); end
      checks++; if (pend_vec !== m_pend) begin failures++; $display("FAIL rnd_pend cyc%0d: got %b expected %b", cyc, pend_vec, m_pend); end
      checks++; if (ovf_err !== m_ovf) begin failures++; $display("FAIL rnd_ovf cyc%0d: got %b expected %b", cyc, ovf_err, m_ovf); end
`ifdef PULSE_ARB_DROP_CNT_EN
      checks++; if (drop_cnt !== 8'(m_drop)) begin failures++; $display("FAIL rnd_drop cyc%0d: got %0d expected %0d", cyc, drop_cnt, m_drop); end
`endif
      if (grant_vld === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL rnd_sb cyc%0d: got grant id=%0d expected no grant", cyc, grant_id);
        end else begin
          exp_id = exp_q.pop_front();
          if (grant_id !== exp_id) begin failures++; $display("FAIL rnd_sb cyc%0d: got id=%0d expected id=%0d", cyc, grant_id, exp_id); end
        end
      end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rnd_sb_left: got %0d unserved grants expected 0", exp_q.size()); end
    rst = 1'b1; req_lvl = '0; res_done = 1'b0; clr_err = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b0; req_lvl = '0; res_done = 1'b0; clr_err = 1'b0;
    test_reset();
    test_single_grant();
    test_round_robin();
    test_overflow();
    test_reset_in_wait();
    test_back_to_back();
`ifdef PULSE_ARB_DROP_CNT_EN
    test_drop_cnt();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
